// File: rtl/video_mode_ctrl.sv
// Video mode controller: shadow timing registers, validated commits,
// and video enable sequencing that only switches at frame boundaries.
module video_mode_ctrl #(
  parameter int unsigned     TO_W   = 24,
  parameter logic [TO_W-1:0] TO_CYC = 24'd2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        eov,
  output logic        ctrl_ven,
  output logic        ctrl_hsync_pol,
  output logic        ctrl_vsync_pol,
  output logic        ctrl_blank_pol,
  output logic        ctrl_daten_pol,
  output logic [7:0]  Thsync,
  output logic [7:0]  Thgdel,
  output logic [15:0] Thgate,
  output logic [15:0] Thlen,
  output logic [7:0]  Tvsync,
  output logic [7:0]  Tvgdel,
  output logic [15:0] Tvgate,
  output logic [15:0] Tvlen,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_ON  = 3'd1,
    S_RUN      = 3'd2,
    S_WAIT_EOV = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t          r_state, w_nxt;
  logic [4:0]      r_ctl;
  logic [15:0]     r_h0, r_v0;
  logic [31:0]     r_h1, r_v1;
  logic [TO_W-1:0] r_to;
  logic            r_ven, r_err;
  logic [31:0]     w_rd;

  logic        w_commit, w_ok, w_hok, w_vok;
  logic [16:0] w_hsum, w_vsum;
  logic        w_pend, w_to_hit, w_evt;
  logic        w_apply, w_ven_on, w_ven_off, w_err_set;
  logic        w_err_clr;

  assign w_commit  = wr_en && (wr_addr == 3'd5);
  assign w_err_clr = wr_en && (wr_addr == 3'd0) && wr_data[8];

  // 17-bit sums so the 8+8+16 bit addition cannot wrap.
  assign w_hsum = {9'd0, r_h0[7:0]} + {9'd0, r_h0[15:8]}
                + {1'b0, r_h1[15:0]};
  assign w_vsum = {9'd0, r_v0[7:0]} + {9'd0, r_v0[15:8]}
                + {1'b0, r_v1[15:0]};
  assign w_hok  = w_hsum < {1'b0, r_h1[31:16]};
  assign w_vok  = w_vsum < {1'b0, r_v1[31:16]};
  assign w_ok   = w_hok && w_vok;

  assign w_pend   = (r_state == S_WAIT_EOV) || (r_state == S_DRAIN);
  assign w_to_hit = w_pend && (r_to == TO_CYC - TO_W'(1));
  assign w_evt    = eov || w_to_hit;

  always_comb begin
    w_nxt     = r_state;
    w_apply   = 1'b0;
    w_ven_on  = 1'b0;
    w_ven_off = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      S_IDLE, S_WAIT_ON: begin
        w_apply   = w_commit && w_ok;
        w_err_set = w_commit && !w_ok;
        if (r_state == S_WAIT_ON) begin
          w_ven_on = 1'b1;
          w_nxt    = S_RUN;
        end else if (r_ctl[0]) begin
          w_nxt = S_WAIT_ON;
        end
      end
      S_RUN: begin
        w_err_set = w_commit && !w_ok;
        if (w_commit && w_ok)
          w_nxt = S_WAIT_EOV;
        else if (!r_ctl[0])
          w_nxt = S_DRAIN;
      end
      S_WAIT_EOV: begin
        if (w_evt) begin
          w_apply   = 1'b1;
          w_err_set = !eov;
          w_nxt     = r_ctl[0] ? S_RUN : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_evt) begin
          w_ven_off = 1'b1;
          w_err_set = !eov;
          w_nxt     = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_to    <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)
        r_to <= '0;
      else if (w_pend)
        r_to <= r_to + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl <= '0;
      r_h0  <= '0;
      r_h1  <= '0;
      r_v0  <= '0;
      r_v1  <= '0;
    end else if (wr_en) begin
      unique case (1'b1)
        wr_addr == 3'd0: r_ctl <= wr_data[4:0];
        wr_addr == 3'd1: r_h0  <= wr_data[15:0];
        wr_addr == 3'd2: r_h1  <= wr_data;
        wr_addr == 3'd3: r_v0  <= wr_data[15:0];
        wr_addr == 3'd4: r_v1  <= wr_data;
        default: ;
      endcase
    end
  end

  // Live copy reads pre-edge shadow values, so a same-cycle write waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_hsync_pol <= 1'b0;
      ctrl_vsync_pol <= 1'b0;
      ctrl_blank_pol <= 1'b0;
      ctrl_daten_pol <= 1'b0;
      Thsync <= '0;
      Thgdel <= '0;
      Thgate <= '0;
      Thlen  <= '0;
      Tvsync <= '0;
      Tvgdel <= '0;
      Tvgate <= '0;
      Tvlen  <= '0;
    end else if (w_apply) begin
      ctrl_hsync_pol <= r_ctl[1];
      ctrl_vsync_pol <= r_ctl[2];
      ctrl_blank_pol <= r_ctl[3];
      ctrl_daten_pol <= r_ctl[4];
      Thsync <= r_h0[7:0];
      Thgdel <= r_h0[15:8];
      Thgate <= r_h1[15:0];
      Thlen  <= r_h1[31:16];
      Tvsync <= r_v0[7:0];
      Tvgdel <= r_v0[15:8];
      Tvgate <= r_v1[15:0];
      Tvlen  <= r_v1[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ven <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_ven_on)
        r_ven <= 1'b1;
      else if (w_ven_off)
        r_ven <= 1'b0;
      if (w_err_set)
        r_err <= 1'b1;
      else if (w_err_clr)
        r_err <= 1'b0;
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (rd_addr)
      3'd0: w_rd = {27'd0, r_ctl};
      3'd1: w_rd = {16'd0, r_h0};
      3'd2: w_rd = r_h1;
      3'd3: w_rd = {16'd0, r_v0};
      3'd4: w_rd = r_v1;
      3'd6: w_rd = {25'd0, r_state, 1'b0,
                    r_err, w_pend, r_ven};
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else
      rd_data <= w_rd;
  end

  assign ctrl_ven = r_ven;
  assign busy     = w_pend;
  assign err      = r_err;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: commits, enable sequencing,
// validation errors, frame-edge timeout and asynchronous reset.
module tb_video_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        eov = 1'b0;
  logic        ctrl_ven, ctrl_hsync_pol, ctrl_vsync_pol;
  logic        ctrl_blank_pol, ctrl_daten_pol;
  logic [7:0]  Thsync, Thgdel, Tvsync, Tvgdel;
  logic [15:0] Thgate, Thlen, Tvgate, Tvlen;
  logic        busy, err;

  int checks = 0;
  int failures = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  video_mode_ctrl #(.TO_W(24), .TO_CYC(24'd16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .eov(eov),
    .ctrl_ven(ctrl_ven),
    .ctrl_hsync_pol(ctrl_hsync_pol),
    .ctrl_vsync_pol(ctrl_vsync_pol),
    .ctrl_blank_pol(ctrl_blank_pol),
    .ctrl_daten_pol(ctrl_daten_pol),
    .Thsync(Thsync), .Thgdel(Thgdel),
    .Thgate(Thgate), .Thlen(Thlen),
    .Tvsync(Tvsync), .Tvgdel(Tvgdel),
    .Tvgate(Tvgate), .Tvlen(Tvlen),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_eov();
    eov = 1'b1;
    tick(1);
    eov = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    rd_addr = a;
    tick(1);
    d = rd_data;
  endtask

  initial begin
    #23;
    chk("rst_ven", 32'(ctrl_ven), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_thlen", 32'(Thlen), 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Mode programming and immediate commit while idle
    wr(3'd1, 32'h0000_0A05);
    wr(3'd2, 32'h0320_0280);
    wr(3'd3, 32'h0000_0A02);
    wr(3'd4, 32'h020D_01E0);
    chk("pre_commit_thlen", 32'(Thlen), 32'd0);
    wr(3'd5, 32'd0);
    chk("idle_thlen", 32'(Thlen), 32'd800);
    chk("idle_tvlen", 32'(Tvlen), 32'd525);
    chk("idle_thsync", 32'(Thsync), 32'd5);
    chk("idle_thgdel", 32'(Thgdel), 32'd10);
    chk("idle_tvgate", 32'(Tvgate), 32'd480);
    chk("idle_busy", 32'(busy), 32'd0);
    rd(3'd2, rv);
    chk("rd_h1", rv, 32'h0320_0280);

    // Enable: ven rises two clocks after the CTRL write
    wr(3'd0, 32'd1);
    chk("ven_t0", 32'(ctrl_ven), 32'd0);
    tick(1);
    chk("ven_t1", 32'(ctrl_ven), 32'd0);
    tick(1);
    chk("ven_t2", 32'(ctrl_ven), 32'd1);
    rd(3'd6, rv);
    chk("status_run", rv, 32'h0000_0021);

    // Commit in RUN waits for eov; duplicate commit ignored
    wr(3'd2, 32'h0384_0280);
    wr(3'd5, 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_thlen_hold", 32'(Thlen), 32'd800);
    wr(3'd5, 32'd0);
    chk("dup_busy", 32'(busy), 32'd1);
    tick(2);
    chk("run_thlen_hold2", 32'(Thlen), 32'd800);
    // Shadow write coinciding with eov: live takes the old shadow
    eov = 1'b1;
    wr(3'd2, 32'h03E8_0280);
    eov = 1'b0;
    chk("eov_thlen", 32'(Thlen), 32'd900);
    chk("eov_busy", 32'(busy), 32'd0);
    chk("eov_err", 32'(err), 32'd0);
    pulse_eov();
    chk("eov_run_ignored", 32'(Thlen), 32'd900);

    // Invalid commit: Thgate == Thlen
    wr(3'd2, 32'h0320_0320);
    wr(3'd5, 32'd0);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_thlen", 32'(Thlen), 32'd900);
    wr(3'd0, 32'h0000_0101);
    chk("errclr", 32'(err), 32'd0);
    chk("errclr_ven", 32'(ctrl_ven), 32'd1);

    // Timeout: eov held low, forced update on the 16th clock
    wr(3'd2, 32'h03E8_0280);
    wr(3'd5, 32'd0);
    tick(15);
    chk("to_hold", 32'(Thlen), 32'd900);
    chk("to_hold_err", 32'(err), 32'd0);
    tick(1);
    chk("to_thlen", 32'(Thlen), 32'd1000);
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    wr(3'd0, 32'h0000_0101);

    // Disable drains to the next frame edge
    wr(3'd0, 32'd0);
    tick(1);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_ven", 32'(ctrl_ven), 32'd1);
    tick(3);
    chk("drain_ven2", 32'(ctrl_ven), 32'd1);
    pulse_eov();
    chk("off_ven", 32'(ctrl_ven), 32'd0);
    chk("off_busy", 32'(busy), 32'd0);
    rd(3'd6, rv);
    chk("status_idle", rv, 32'd0);
    pulse_eov();
    chk("eov_idle_ignored", 32'(Thlen), 32'd1000);

    // Asynchronous reset drops a pending commit
    wr(3'd0, 32'd1);
    tick(2);
    chk("re_ven", 32'(ctrl_ven), 32'd1);
    wr(3'd2, 32'h04B0_0280);
    wr(3'd5, 32'd0);
    chk("re_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ven", 32'(ctrl_ven), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_thlen", 32'(Thlen), 32'd0);
    chk("ar_tvlen", 32'(Tvlen), 32'd0);
    chk("ar_thsync", 32'(Thsync), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_eov();
    chk("post_rst_thlen", 32'(Thlen), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    rd(3'd2, rv);
    chk("post_rst_shadow", rv, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
